// File: rtl/ticket_vendor.sv
// Binary-credit ticket vendor: one dispense pulse per sale, one return_sig pulse per UNIT of change, cancel refund, over-limit reject.
// Define TICKET_SALES_CNT_EN to add the saturating tickets_sold counter.
module ticket_vendor #(
  parameter int PRICE      = 30,
  parameter int UNIT       = 10,
  parameter int TEN_VAL    = 10,
  parameter int TWENTY_VAL = 20,
  parameter int MAX_CREDIT = 60,
  parameter int CREDIT_W   = 8,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                ten,
  input  logic                twenty,
  input  logic                cancel,
  output logic                ready,
  output logic                bill,
  output logic                dispense,
  output logic                return_sig,
  output logic                reject,
  output logic [CREDIT_W-1:0] credit
`ifdef TICKET_SALES_CNT_EN
  ,
  output logic [CNT_W-1:0]    tickets_sold
`endif
);

  if (PRICE <= 0 || UNIT <= 0 || TEN_VAL <= 0 || TWENTY_VAL <= 0 ||
      (PRICE % UNIT) != 0 || (TEN_VAL % UNIT) != 0 || (TWENTY_VAL % UNIT) != 0 ||
      MAX_CREDIT < PRICE || CREDIT_W < 1 || CREDIT_W > 31 || CNT_W < 1 ||
      (MAX_CREDIT + TWENTY_VAL) >= (1 << CREDIT_W)) begin : g_param_check
    $error("ticket_vendor: illegal parameter combination");
  end

  localparam logic [1:0] ST_RDY  = 2'd0;
  localparam logic [1:0] ST_BILL = 2'd1;
  localparam logic [1:0] ST_DISP = 2'd2;
  localparam logic [1:0] ST_RTN  = 2'd3;

  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_C   = CREDIT_W'(UNIT);
  localparam logic [CREDIT_W-1:0] TEN_C    = CREDIT_W'(TEN_VAL);
  localparam logic [CREDIT_W-1:0] TWENTY_C = CREDIT_W'(TWENTY_VAL);
  localparam logic [CREDIT_W-1:0] MAX_C    = CREDIT_W'(MAX_CREDIT);

  logic [1:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                reject_q, reject_d;

  logic                coin_vld;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic [CREDIT_W-1:0] after_price;
  logic [CREDIT_W-1:0] after_unit;

  // ten takes precedence when both coin strobes arrive together
  assign coin_vld    = ten | twenty;
  assign coin_val    = ten ? TEN_C : TWENTY_C;
  assign sum         = credit_q + coin_val;
  assign after_price = credit_q - PRICE_C;
  assign after_unit  = credit_q - UNIT_C;

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    case (state_q)
      ST_RDY, ST_BILL: begin
        if (coin_vld) begin
          if (sum > MAX_C) begin
            reject_d = 1'b1;
          end else begin
            credit_d = sum;
            state_d  = (sum >= PRICE_C) ? ST_DISP : ST_BILL;
          end
        end else if (cancel && state_q == ST_BILL) begin
          state_d = ST_RTN;
        end
      end
      ST_DISP: begin
        reject_d = coin_vld;
        credit_d = after_price;
        state_d  = (after_price == '0) ? ST_RDY : ST_RTN;
      end
      ST_RTN: begin
        reject_d = coin_vld;
        credit_d = after_unit;
        state_d  = (after_unit == '0) ? ST_RDY : ST_RTN;
      end
      default: begin
        state_d  = ST_RDY;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= ST_RDY;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  assign ready      = (state_q == ST_RDY);
  assign bill       = (state_q == ST_BILL);
  assign dispense   = (state_q == ST_DISP);
  assign return_sig = (state_q == ST_RTN);
  assign reject     = reject_q;
  assign credit     = credit_q;

`ifdef TICKET_SALES_CNT_EN
  logic [CNT_W-1:0] sold_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      sold_q <= '0;
    end else if (state_q == ST_DISP && sold_q != {CNT_W{1'b1}}) begin
      sold_q <= sold_q + CNT_W'(1);
    end
  end

  assign tickets_sold = sold_q;
`endif

endmodule

// File: tb/tb_ticket_vendor.sv
// Bench for ticket_vendor: directed vector table, random run against a count-based model, and a tight-limit instance.
module tb_ticket_vendor;

  localparam int PRICE = 30;
  localparam int UNIT  = 10;
  localparam int TENV  = 10;
  localparam int TWV   = 20;
  localparam int MAXC  = 60;

  localparam logic [4:0] R  = 5'b10000;
  localparam logic [4:0] B  = 5'b01000;
  localparam logic [4:0] D  = 5'b00100;
  localparam logic [4:0] T  = 5'b00010;
  localparam logic [4:0] RJ = 5'b00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear = 1'b0, ten = 1'b0, twenty = 1'b0, cancel = 1'b0;
  logic       ready, bill, dispense, return_sig, reject;
  logic [7:0] credit;

  logic       l_clear = 1'b0, l_ten = 1'b0, l_twenty = 1'b0, l_cancel = 1'b0;
  logic       l_ready, l_bill, l_dispense, l_return_sig, l_reject;
  logic [7:0] l_credit;

`ifdef TICKET_SALES_CNT_EN
  logic [15:0] tickets_sold, l_tickets_sold;
`endif

  ticket_vendor dut (
    .clk(clk), .clear(clear), .ten(ten), .twenty(twenty), .cancel(cancel),
    .ready(ready), .bill(bill), .dispense(dispense), .return_sig(return_sig),
    .reject(reject), .credit(credit)
`ifdef TICKET_SALES_CNT_EN
    , .tickets_sold(tickets_sold)
`endif
  );

  ticket_vendor #(.PRICE(50), .MAX_CREDIT(50)) u_lim (
    .clk(clk), .clear(l_clear), .ten(l_ten), .twenty(l_twenty), .cancel(l_cancel),
    .ready(l_ready), .bill(l_bill), .dispense(l_dispense), .return_sig(l_return_sig),
    .reject(l_reject), .credit(l_credit)
`ifdef TICKET_SALES_CNT_EN
    , .tickets_sold(l_tickets_sold)
`endif
  );

  typedef struct {
    logic       t, tw, c, cl;
    logic [4:0] flags;
    logic [7:0] cr;
  } vec_t;

  vec_t tbl[$];
  int   tests = 0;
  int   failed = 0;

  // reference model: credit plus a dispense flag and a count of outstanding change pulses
  int m_cr, m_ret, m_sold;
  bit m_disp, m_rej;

  task automatic add(input logic t, input logic tw, input logic c, input logic cl,
                     input logic [4:0] f, input int cr);
    vec_t v;
    v.t = t; v.tw = tw; v.c = c; v.cl = cl; v.flags = f; v.cr = 8'(cr);
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got flags/credit=%b/%0d expected %b/%0d",
               name, act[12:8], act[7:0], exp[12:8], exp[7:0]);
    end
  endtask

  task automatic step(input logic t, input logic tw, input logic c, input logic cl);
    @(negedge clk);
    ten = t; twenty = tw; cancel = c; clear = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic l_step(input logic t, input logic tw, input logic c, input logic cl);
    @(negedge clk);
    l_ten = t; l_twenty = tw; l_cancel = c; l_clear = cl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] dut_vec();
    return {ready, bill, dispense, return_sig, reject, credit};
  endfunction

  function automatic logic [12:0] lim_vec();
    return {l_ready, l_bill, l_dispense, l_return_sig, l_reject, l_credit};
  endfunction

  task automatic model_step(input bit t, input bit tw, input bit c, input bit cl);
    bit coin;
    int v;
    coin = t | tw;
    v    = t ? TENV : TWV;
    if (cl) begin
      m_cr = 0; m_ret = 0; m_disp = 0; m_rej = 0; m_sold = 0;
    end else if (m_disp) begin
      if (m_sold < 65535) m_sold++;
      m_cr  -= PRICE;
      m_ret  = m_cr / UNIT;
      m_disp = 0;
      m_rej  = coin;
    end else if (m_ret > 0) begin
      m_cr -= UNIT;
      m_ret--;
      m_rej = coin;
    end else begin
      m_rej = 0;
      if (coin) begin
        if (m_cr + v > MAXC) m_rej = 1;
        else begin
          m_cr += v;
          m_disp = (m_cr >= PRICE);
        end
      end else if (c && m_cr > 0) begin
        m_ret = m_cr / UNIT;
      end
    end
  endtask

  function automatic logic [12:0] model_vec();
    logic idle;
    idle = !m_disp && m_ret == 0;
    return {idle && m_cr == 0, idle && m_cr > 0, m_disp, m_ret > 0, m_rej, 8'(m_cr)};
  endfunction

  initial begin
    //   ten twenty cancel clear  flags   credit
    add(0, 0, 0, 1, R,      0);
    add(0, 0, 0, 0, R,      0);
    add(0, 0, 0, 0, R,      0);
    add(0, 0, 0, 0, R,      0);
    add(0, 1, 0, 0, B,      20);
    add(0, 1, 0, 0, D,      40);
    add(0, 0, 0, 0, T,      10);
    add(0, 0, 0, 0, R,      0);
    add(1, 0, 0, 0, B,      10);
    add(1, 0, 0, 0, B,      20);
    add(1, 0, 0, 0, D,      30);
    add(0, 0, 0, 0, R,      0);
    add(1, 0, 0, 0, B,      10);
    add(0, 0, 1, 0, T,      10);
    add(0, 0, 0, 0, R,      0);
    add(0, 0, 1, 0, R,      0);
    add(1, 1, 0, 0, B,      10);
    add(0, 1, 0, 0, D,      30);
    add(0, 1, 0, 0, R | RJ, 0);
    add(1, 0, 1, 0, B,      10);
    add(1, 0, 0, 0, B,      20);
    add(0, 0, 1, 0, T,      20);
    add(0, 0, 0, 0, T,      10);
    add(0, 0, 0, 0, R,      0);
    add(0, 1, 0, 0, B,      20);
    add(0, 1, 0, 0, D,      40);
    add(0, 1, 1, 0, T | RJ, 10);
    add(1, 0, 0, 0, R | RJ, 0);
    add(1, 0, 0, 0, B,      10);
    add(0, 1, 0, 0, D,      30);
    add(0, 0, 0, 0, R,      0);
    add(1, 1, 0, 0, B,      10);
    add(1, 0, 0, 0, B,      20);
    add(0, 0, 1, 0, T,      20);
    add(0, 0, 0, 1, R,      0);
    add(0, 0, 0, 0, R,      0);
    add(0, 0, 0, 0, R,      0);

    for (int i = 0; i < tbl.size(); i++) begin
`ifdef TICKET_SALES_CNT_EN
      if (i == 34) begin
        tests++;
        if (tickets_sold !== 16'd5) begin
          failed++;
          $display("FAIL sold_before_clear: got %0d expected 5", tickets_sold);
        end
      end
`endif
      step(tbl[i].t, tbl[i].tw, tbl[i].c, tbl[i].cl);
      check($sformatf("vec%0d", i), dut_vec(), {tbl[i].flags, tbl[i].cr});
    end
`ifdef TICKET_SALES_CNT_EN
    tests++;
    if (tickets_sold !== 16'd0) begin
      failed++;
      $display("FAIL sold_after_clear: got %0d expected 0", tickets_sold);
    end
`endif

    // random run against the model
    step(0, 0, 0, 1);
    model_step(0, 0, 0, 1);
    for (int n = 0; n < 2000; n++) begin
      bit rt, rtw, rc, rcl;
      rt  = ($urandom_range(3) == 0);
      rtw = ($urandom_range(3) == 0);
      rc  = ($urandom_range(5) == 0);
      rcl = ($urandom_range(59) == 0);
      step(rt, rtw, rc, rcl);
      model_step(rt, rtw, rc, rcl);
      check($sformatf("rand%0d", n), dut_vec(), model_vec());
`ifdef TICKET_SALES_CNT_EN
      tests++;
      if (tickets_sold !== 16'(m_sold)) begin
        failed++;
        $display("FAIL rand_sold%0d: got %0d expected %0d", n, tickets_sold, m_sold);
      end
`endif
    end
    step(0, 0, 0, 0);

    // credit limit equal to price: third twenty would overflow the limit
    l_step(0, 0, 0, 1); check("lim_clear",   lim_vec(), {R, 8'd0});
    l_step(0, 1, 0, 0); check("lim_20",      lim_vec(), {B, 8'd20});
    l_step(0, 1, 0, 0); check("lim_40",      lim_vec(), {B, 8'd40});
    l_step(0, 1, 0, 0); check("lim_reject",  lim_vec(), {B | RJ, 8'd40});
    l_step(0, 0, 0, 0); check("lim_hold",    lim_vec(), {B, 8'd40});
    l_step(1, 0, 0, 0); check("lim_disp",    lim_vec(), {D, 8'd50});
    l_step(0, 1, 0, 0); check("lim_disp_rj", lim_vec(), {R | RJ, 8'd0});
    l_step(0, 0, 0, 0); check("lim_idle",    lim_vec(), {R, 8'd0});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
